// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// Optional macro SERSUB_OVF_EN adds the signed-overflow flag.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERSUB_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout
`ifdef SERSUB_OVF_EN
        , ovf
`endif
    );

    // Subtractor side
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout
`ifdef SERSUB_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = a - b - bin, DIGIT bits per clock, LSB digit first.
// Optional macro SERSUB_OVF_EN adds a signed-overflow output held with d.
module serial_subtractor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned NDIG     = WIDTH / DIGIT;
    localparam int unsigned CNT_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);
    localparam logic [WIDTH-1:0] DIG_MASK = WIDTH'({DIGIT{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic             br_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bout_q;
    logic             in_ready_q;
    logic             out_valid_q;
`ifdef SERSUB_OVF_EN
    logic             ovf_q;
`endif

    logic             accept_c;
    logic             last_c;
    int unsigned      base_c;
    logic [DIGIT-1:0] x_dig_c;
    logic [DIGIT-1:0] y_dig_c;
    logic [DIGIT-1:0] d_dig_c;
    logic             br_c;
    logic [WIDTH-1:0] d_nxt_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state decode and operand-accept strobe
    always_comb begin
        state_nxt = state_q;
        accept_c  = 1'b0;
        last_c    = (cnt_q == CNT_LAST);
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_c) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Full-subtractor chain over the current digit, merged into d at its position
    always_comb begin
        base_c  = 32'(cnt_q) * DIGIT;
        x_dig_c = DIGIT'(a_q >> base_c);
        y_dig_c = DIGIT'(b_q >> base_c);
        d_dig_c = '0;
        br_c    = br_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            d_dig_c[i] = x_dig_c[i] ^ y_dig_c[i] ^ br_c;
            br_c       = (~x_dig_c[i] & y_dig_c[i]) | (~x_dig_c[i] & br_c) | (y_dig_c[i] & br_c);
        end
        d_nxt_c = (d_q & ~(DIG_MASK << base_c)) | (WIDTH'(d_dig_c) << base_c);
    end

    // Operand capture and digit-serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            bout_q <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            if (accept_c) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                br_q  <= bus.bin;
                cnt_q <= '0;
            end
            if (state_q == S_RUN) begin
                d_q   <= d_nxt_c;
                br_q  <= br_c;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_c) begin
                    bout_q <= br_c;
`ifdef SERSUB_OVF_EN
                    ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_nxt_c[WIDTH-1] ^ a_q[WIDTH-1]);
`endif
                end
            end
        end
    end

    // Handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt == S_IDLE);
            out_valid_q <= (state_nxt == S_DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
`ifdef SERSUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at DIGIT = 4, 1 and 16 (WIDTH 16).
module tb_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a_s = '0;
    logic [15:0] b_s = '0;
    logic        bin_s = 1'b0;
    logic [2:0]  in_valid_s = '0;
    logic        out_ready_s = 1'b1;

    logic [2:0]  ov_w;
    logic [2:0]  ir_w;
    logic [2:0]  bo_w;
    logic [15:0] d_w [3];
`ifdef SERSUB_OVF_EN
    logic [2:0]  ovf_w;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int lat_exp [3] = '{4, 16, 1};

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(16)) if_d4  ();
    serial_subtractor_if #(.WIDTH(16)) if_d1  ();
    serial_subtractor_if #(.WIDTH(16)) if_d16 ();

    serial_subtractor #(.WIDTH(16), .DIGIT(4))  u_d4  (.clk(clk), .rst_n(rst_n), .bus(if_d4.slave));
    serial_subtractor #(.WIDTH(16), .DIGIT(1))  u_d1  (.clk(clk), .rst_n(rst_n), .bus(if_d1.slave));
    serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(if_d16.slave));

    assign if_d4.in_valid  = in_valid_s[0];
    assign if_d1.in_valid  = in_valid_s[1];
    assign if_d16.in_valid = in_valid_s[2];
    assign if_d4.a  = a_s;   assign if_d1.a  = a_s;   assign if_d16.a  = a_s;
    assign if_d4.b  = b_s;   assign if_d1.b  = b_s;   assign if_d16.b  = b_s;
    assign if_d4.bin = bin_s; assign if_d1.bin = bin_s; assign if_d16.bin = bin_s;
    assign if_d4.out_ready = out_ready_s;
    assign if_d1.out_ready = out_ready_s;
    assign if_d16.out_ready = out_ready_s;

    assign ov_w = {if_d16.out_valid, if_d1.out_valid, if_d4.out_valid};
    assign ir_w = {if_d16.in_ready,  if_d1.in_ready,  if_d4.in_ready};
    assign bo_w = {if_d16.bout,      if_d1.bout,      if_d4.bout};
    assign d_w[0] = if_d4.d;
    assign d_w[1] = if_d1.d;
    assign d_w[2] = if_d16.d;
`ifdef SERSUB_OVF_EN
    assign ovf_w = {if_d16.ovf, if_d1.ovf, if_d4.ovf};
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on the selected instances; checks latency and result of each
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, input logic [2:0] en,
                         input logic [15:0] exp_d, input logic exp_b, input logic exp_ovf);
        int          lat [3];
        logic [15:0] cap_d [3];
        logic [2:0]  cap_b;
        logic [2:0]  cap_o;
        lat   = '{0, 0, 0};
        cap_d = '{16'h0, 16'h0, 16'h0};
        cap_b = '0;
        cap_o = '0;
        @(negedge clk);
        for (int j = 0; j < 3; j++)
            if (en[j]) check($sformatf("%s_u%0d_rdy", tag, j), 32'(ir_w[j]), 32'd1);
        a_s = a; b_s = b; bin_s = bi; in_valid_s = en;
        @(negedge clk);
        in_valid_s = '0;
        a_s = ~a; b_s = ~b; bin_s = ~bi;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (en[j] && ov_w[j] && lat[j] == 0) begin
                    lat[j]   = c;
                    cap_d[j] = d_w[j];
                    cap_b[j] = bo_w[j];
`ifdef SERSUB_OVF_EN
                    cap_o[j] = ovf_w[j];
`endif
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (en[j]) begin
                check($sformatf("%s_u%0d_lat", tag, j), 32'(lat[j]), 32'(lat_exp[j]));
                check($sformatf("%s_u%0d_d", tag, j), 32'(cap_d[j]), 32'(exp_d));
                check($sformatf("%s_u%0d_bout", tag, j), 32'(cap_b[j]), 32'(exp_b));
`ifdef SERSUB_OVF_EN
                check($sformatf("%s_u%0d_ovf", tag, j), 32'(cap_o[j]), 32'(exp_ovf));
`else
                if (cap_o[j] != 1'b0 || exp_ovf == 1'b1) begin end
`endif
            end
        end
    endtask

    initial begin
        int          lat;
        logic [15:0] hold_d;

        // Reset state
        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("rst_u%0d_d", j), 32'(d_w[j]), 32'h0);
            check($sformatf("rst_u%0d_ov", j), 32'(ov_w[j]), 32'h0);
            check($sformatf("rst_u%0d_bout", j), 32'(bo_w[j]), 32'h0);
            check($sformatf("rst_u%0d_rdy", j), 32'(ir_w[j]), 32'h1);
`ifdef SERSUB_OVF_EN
            check($sformatf("rst_u%0d_ovf", j), 32'(ovf_w[j]), 32'h0);
`endif
        end
        rst_n = 1'b1;

        // Basic arithmetic on all three digit sizes
        do_op("t1",   16'h1234, 16'h0234, 1'b0, 3'b111, 16'h1000, 1'b0, 1'b0);
        do_op("t2",   16'h0000, 16'h0001, 1'b0, 3'b111, 16'hFFFF, 1'b1, 1'b0);
        do_op("t3a",  16'h0005, 16'h0005, 1'b1, 3'b111, 16'hFFFF, 1'b1, 1'b0);
        do_op("t3b",  16'h0005, 16'h0005, 1'b0, 3'b111, 16'h0000, 1'b0, 1'b0);
        do_op("t6a",  16'h8000, 16'h0001, 1'b0, 3'b111, 16'h7FFF, 1'b0, 1'b1);
        do_op("t6b",  16'h7FFF, 16'hFFFF, 1'b0, 3'b111, 16'h8000, 1'b1, 1'b1);
        do_op("t6c",  16'h0003, 16'h0001, 1'b0, 3'b111, 16'h0002, 1'b0, 1'b0);

        // Back-pressure: result held, input side closed, stray in_valid ignored
        @(negedge clk);
        out_ready_s = 1'b0;
        a_s = 16'h1234; b_s = 16'h0234; bin_s = 1'b0; in_valid_s = 3'b001;
        @(negedge clk);
        in_valid_s = '0;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (ov_w[0]) lat = c;
        end
        check("bp_lat", 32'(lat), 32'd4);
        hold_d = 16'h1000;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_d", k), 32'(d_w[0]), 32'(hold_d));
            check($sformatf("bp%0d_bout", k), 32'(bo_w[0]), 32'h0);
            check($sformatf("bp%0d_ov", k), 32'(ov_w[0]), 32'h1);
            check($sformatf("bp%0d_rdy", k), 32'(ir_w[0]), 32'h0);
            if (k == 1) begin
                a_s = 16'hFFFF; b_s = 16'h0001; in_valid_s = 3'b001;
            end
            @(negedge clk);
            in_valid_s = '0;
        end
        out_ready_s = 1'b1;
        @(negedge clk);
        check("bp_rel_rdy", 32'(ir_w[0]), 32'h1);
        check("bp_rel_ov", 32'(ov_w[0]), 32'h0);
        repeat (6) @(negedge clk);
        check("bp_ignored_ov", 32'(ov_w[0]), 32'h0);
        check("bp_ignored_rdy", 32'(ir_w[0]), 32'h1);

        // Mid-operation reset discards the op
        a_s = 16'hFFFF; b_s = 16'h1111; bin_s = 1'b0; in_valid_s = 3'b001;
        @(negedge clk);
        in_valid_s = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_d", 32'(d_w[0]), 32'h0);
        check("mr_ov", 32'(ov_w[0]), 32'h0);
        check("mr_rdy", 32'(ir_w[0]), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op("t5", 16'h00FF, 16'h000F, 1'b0, 3'b111, 16'h00F0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
